// File: rtl/bus_pkg.sv
// Shared types and widths for the core bus arbiter.
// Imported by the arbiter for its state and owner encodings.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_EXEC  = 1'b1
   } owner_e;

endpackage : bus_pkg

// File: rtl/bus_arbiter.sv
// Shares the single external bus between instruction fetch and execute,
// running one valid/ready transaction at a time with a timeout abort.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned STARVE_LIMIT   = 8
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  fetch_request,
   input  logic [BUS_ADDR_W-1:0] fetch_address,
   output logic                  fetch_grant,
   output logic                  fetch_done,
   output logic                  fetch_error,
   output logic [BUS_DATA_W-1:0] fetch_read_data,

   input  logic                  exec_request,
   input  logic                  exec_write,
   input  logic [BUS_ADDR_W-1:0] exec_address,
   input  logic [BUS_DATA_W-1:0] exec_write_data,
   output logic                  exec_grant,
   output logic                  exec_done,
   output logic                  exec_error,
   output logic [BUS_DATA_W-1:0] exec_read_data,

   output logic                  bus_vaild,
   input  logic                  bus_ready,
   output logic                  bus_write_enable,
   output logic [BUS_ADDR_W-1:0] bus_address,
   output logic [BUS_DATA_W-1:0] bus_write_data,
   input  logic [BUS_DATA_W-1:0] bus_data
);

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
   localparam logic [3:0] STARVE_VAL  = 4'(STARVE_LIMIT);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  bus_vaild_q, bus_vaild_d;
   logic                  bus_we_q, bus_we_d;
   logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [7:0]            timeout_cnt_q, timeout_cnt_d;
   logic [3:0]            fetch_wait_q, fetch_wait_d;
   logic                  fetch_grant_q, fetch_grant_d;
   logic                  exec_grant_q, exec_grant_d;
   logic                  fetch_done_q, fetch_done_d;
   logic                  exec_done_q, exec_done_d;
   logic                  fetch_error_q, fetch_error_d;
   logic                  exec_error_q, exec_error_d;
   logic [BUS_DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
   logic [BUS_DATA_W-1:0] exec_rdata_q, exec_rdata_d;
   logic                  fetch_wins;

   // Execute has priority unless fetch has been starved long enough.
   assign fetch_wins = fetch_request &&
                       (!exec_request || (fetch_wait_q >= STARVE_VAL));

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      bus_vaild_d   = bus_vaild_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      timeout_cnt_d = timeout_cnt_q;
      fetch_wait_d  = fetch_wait_q;
      fetch_grant_d = 1'b0;
      exec_grant_d  = 1'b0;
      fetch_done_d  = 1'b0;
      exec_done_d   = 1'b0;
      fetch_error_d = 1'b0;
      exec_error_d  = 1'b0;
      fetch_rdata_d = fetch_rdata_q;
      exec_rdata_d  = exec_rdata_q;

      case (state_q)
         IDLE: begin
            timeout_cnt_d = '0;
            if (!fetch_request || fetch_wins) begin
               fetch_wait_d = '0;
            end else if (fetch_wait_q != 4'hF) begin
               fetch_wait_d = fetch_wait_q + 4'd1;
            end

            if (fetch_request || exec_request) begin
               state_d     = BUSY;
               bus_vaild_d = 1'b1;
               if (fetch_wins) begin
                  owner_d       = OWNER_FETCH;
                  bus_we_d      = 1'b0;
                  bus_addr_d    = fetch_address;
                  bus_wdata_d   = '0;
                  fetch_grant_d = 1'b1;
               end else begin
                  owner_d      = OWNER_EXEC;
                  bus_we_d     = exec_write;
                  bus_addr_d   = exec_address;
                  bus_wdata_d  = exec_write_data;
                  exec_grant_d = 1'b1;
               end
            end
         end

         BUSY: begin
            if (bus_ready) begin
               state_d       = IDLE;
               bus_vaild_d   = 1'b0;
               timeout_cnt_d = '0;
               if (owner_q == OWNER_FETCH) begin
                  fetch_done_d = 1'b1;
                  if (!bus_we_q) fetch_rdata_d = bus_data;
               end else begin
                  exec_done_d = 1'b1;
                  if (!bus_we_q) exec_rdata_d = bus_data;
               end
            end else if (timeout_cnt_q == TIMEOUT_VAL) begin
               state_d       = IDLE;
               bus_vaild_d   = 1'b0;
               timeout_cnt_d = '0;
               if (owner_q == OWNER_FETCH) begin
                  fetch_done_d  = 1'b1;
                  fetch_error_d = 1'b1;
               end else begin
                  exec_done_d  = 1'b1;
                  exec_error_d = 1'b1;
               end
            end else begin
               timeout_cnt_d = timeout_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d     = IDLE;
            bus_vaild_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= OWNER_FETCH;
         bus_vaild_q   <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         timeout_cnt_q <= '0;
         fetch_wait_q  <= '0;
         fetch_grant_q <= 1'b0;
         exec_grant_q  <= 1'b0;
         fetch_done_q  <= 1'b0;
         exec_done_q   <= 1'b0;
         fetch_error_q <= 1'b0;
         exec_error_q  <= 1'b0;
         fetch_rdata_q <= '0;
         exec_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         bus_vaild_q   <= bus_vaild_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         timeout_cnt_q <= timeout_cnt_d;
         fetch_wait_q  <= fetch_wait_d;
         fetch_grant_q <= fetch_grant_d;
         exec_grant_q  <= exec_grant_d;
         fetch_done_q  <= fetch_done_d;
         exec_done_q   <= exec_done_d;
         fetch_error_q <= fetch_error_d;
         exec_error_q  <= exec_error_d;
         fetch_rdata_q <= fetch_rdata_d;
         exec_rdata_q  <= exec_rdata_d;
      end
   end

   assign fetch_grant      = fetch_grant_q;
   assign fetch_done       = fetch_done_q;
   assign fetch_error      = fetch_error_q;
   assign fetch_read_data  = fetch_rdata_q;
   assign exec_grant       = exec_grant_q;
   assign exec_done        = exec_done_q;
   assign exec_error       = exec_error_q;
   assign exec_read_data   = exec_rdata_q;
   assign bus_vaild        = bus_vaild_q;
   assign bus_write_enable = bus_we_q;
   assign bus_address      = bus_addr_q;
   assign bus_write_data   = bus_wdata_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: write, read, starvation,
// timeout, asynchronous reset and stray-ready scenarios.
module tb_bus_arbiter;

   logic        clock;
   logic        reset;
   logic        fetch_request;
   logic [31:0] fetch_address;
   logic        fetch_grant, fetch_done, fetch_error;
   logic [31:0] fetch_read_data;
   logic        exec_request, exec_write;
   logic [31:0] exec_address, exec_write_data;
   logic        exec_grant, exec_done, exec_error;
   logic [31:0] exec_read_data;
   logic        bus_vaild, bus_ready, bus_write_enable;
   logic [31:0] bus_address, bus_write_data, bus_data;

   int asserts  = 0;
   int failures = 0;

   bus_arbiter #(.TIMEOUT_CYCLES(4), .STARVE_LIMIT(8)) dut (
      .clock(clock), .reset(reset),
      .fetch_request(fetch_request), .fetch_address(fetch_address),
      .fetch_grant(fetch_grant), .fetch_done(fetch_done),
      .fetch_error(fetch_error), .fetch_read_data(fetch_read_data),
      .exec_request(exec_request), .exec_write(exec_write),
      .exec_address(exec_address), .exec_write_data(exec_write_data),
      .exec_grant(exec_grant), .exec_done(exec_done),
      .exec_error(exec_error), .exec_read_data(exec_read_data),
      .bus_vaild(bus_vaild), .bus_ready(bus_ready),
      .bus_write_enable(bus_write_enable), .bus_address(bus_address),
      .bus_write_data(bus_write_data), .bus_data(bus_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (2) @(negedge clock);
      asserts++;
      if ({bus_vaild, fetch_grant, exec_grant, fetch_done, exec_done, fetch_error, exec_error} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {bus_vaild, fetch_grant, exec_grant, fetch_done, exec_done, fetch_error, exec_error});
      end
      asserts++;
      if ({bus_address, bus_write_data, fetch_read_data, exec_read_data} !== 128'b0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h frd=%h erd=%h required all 0",
                  bus_address, bus_write_data, fetch_read_data, exec_read_data);
      end
      reset = 1'b0;
      @(negedge clock);
      asserts++;
      if (bus_vaild !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: bus_vaild=%b required 0", bus_vaild);
      end
      $display("reset: done");
   endtask

   task automatic test_exec_write();
      exec_request = 1'b1; exec_write = 1'b1;
      exec_address = 32'h0000_1000; exec_write_data = 32'hDEAD_BEEF;
      @(negedge clock);
      asserts++;
      if ({exec_grant, fetch_grant, bus_vaild, bus_write_enable} !== 4'b1011) begin
         failures++;
         $display("FAIL wr_grant: grant_e/grant_f/vaild/we=%b required 1011",
                  {exec_grant, fetch_grant, bus_vaild, bus_write_enable});
      end
      asserts++;
      if (bus_address !== 32'h0000_1000 || bus_write_data !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL wr_bus: addr=%h data=%h required 00001000 deadbeef", bus_address, bus_write_data);
      end
      @(negedge clock);
      asserts++;
      if ({exec_grant, bus_vaild, exec_done} !== 3'b010) begin
         failures++;
         $display("FAIL wr_hold: grant/vaild/done=%b required 010", {exec_grant, bus_vaild, exec_done});
      end
      @(negedge clock);
      bus_ready = 1'b1;
      @(negedge clock);
      bus_ready = 1'b0;
      asserts++;
      if ({exec_done, exec_error, bus_vaild} !== 3'b100) begin
         failures++;
         $display("FAIL wr_done: done/error/vaild=%b required 100", {exec_done, exec_error, bus_vaild});
      end
      asserts++;
      if (exec_read_data !== 32'h0) begin
         failures++;
         $display("FAIL wr_rdata: exec_read_data=%h required 00000000", exec_read_data);
      end
      exec_request = 1'b0; exec_write = 1'b0;
      @(negedge clock);
      asserts++;
      if ({exec_done, exec_grant, bus_vaild} !== 3'b000) begin
         failures++;
         $display("FAIL wr_after: done/grant/vaild=%b required 000", {exec_done, exec_grant, bus_vaild});
      end
      $display("exec_write: addr=00001000 data=deadbeef");
   endtask

   task automatic test_fetch_read();
      fetch_request = 1'b1; fetch_address = 32'hFFFF_FFF0;
      @(negedge clock);
      asserts++;
      if ({fetch_grant, exec_grant, bus_vaild, bus_write_enable} !== 4'b1010 ||
          bus_address !== 32'hFFFF_FFF0) begin
         failures++;
         $display("FAIL rd_grant: gf/ge/vaild/we=%b addr=%h required 1010 fffffff0",
                  {fetch_grant, exec_grant, bus_vaild, bus_write_enable}, bus_address);
      end
      bus_ready = 1'b1; bus_data = 32'h1234_5678;
      @(negedge clock);
      bus_ready = 1'b0; bus_data = 32'h0;
      asserts++;
      if ({fetch_done, fetch_error, exec_done, bus_write_enable} !== 4'b1000) begin
         failures++;
         $display("FAIL rd_done: fd/fe/ed/we=%b required 1000",
                  {fetch_done, fetch_error, exec_done, bus_write_enable});
      end
      asserts++;
      if (fetch_read_data !== 32'h1234_5678 || exec_read_data !== 32'h0) begin
         failures++;
         $display("FAIL rd_data: fetch=%h exec=%h required 12345678 00000000",
                  fetch_read_data, exec_read_data);
      end
      fetch_request = 1'b0;
      @(negedge clock);
      $display("fetch_read: addr=fffffff0 data=12345678");
   endtask

   task automatic test_contention();
      logic expect_fetch;
      fetch_request = 1'b1; fetch_address = 32'h0000_3000;
      exec_request  = 1'b1; exec_write    = 1'b0; exec_address = 32'h0000_2000;
      bus_ready     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         expect_fetch = (i == 8);
         @(negedge clock);
         bus_data = 32'hC0DE_0000 | 32'(i);
         asserts++;
         if ({fetch_grant, exec_grant} !== {expect_fetch, !expect_fetch} || bus_vaild !== 1'b1) begin
            failures++;
            $display("FAIL cont_grant[%0d]: gf/ge=%b vaild=%b required %b%b 1",
                     i, {fetch_grant, exec_grant}, bus_vaild, expect_fetch, !expect_fetch);
         end
         @(negedge clock);
         asserts++;
         if ({fetch_done, exec_done} !== {expect_fetch, !expect_fetch} ||
             (expect_fetch ? fetch_read_data : exec_read_data) !== (32'hC0DE_0000 | 32'(i))) begin
            failures++;
            $display("FAIL cont_done[%0d]: fd/ed=%b frd=%h erd=%h required %b%b data c0de%04h",
                     i, {fetch_done, exec_done}, fetch_read_data, exec_read_data,
                     expect_fetch, !expect_fetch, i);
         end
         $display("contention: txn %0d owner=%s", i, expect_fetch ? "fetch" : "exec");
      end
      fetch_request = 1'b0; exec_request = 1'b0; bus_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_timeout();
      int vaild_cycles = 0;
      bit ended = 0;
      exec_request = 1'b1; exec_write = 1'b0; exec_address = 32'h0000_4000;
      bus_ready = 1'b0; bus_data = 32'h5555_AAAA;
      for (int k = 0; k < 20 && !ended; k++) begin
         @(negedge clock);
         if (bus_vaild) vaild_cycles++;
         else ended = 1;
      end
      asserts++;
      if (!ended || vaild_cycles != 5) begin
         failures++;
         $display("FAIL to_length: vaild high %0d cycles ended=%0d required 5 and ended", vaild_cycles, ended);
      end
      asserts++;
      if ({exec_done, exec_error, fetch_done} !== 3'b110) begin
         failures++;
         $display("FAIL to_flags: done/error/fdone=%b required 110", {exec_done, exec_error, fetch_done});
      end
      asserts++;
      if (exec_read_data !== 32'hC0DE_0009) begin
         failures++;
         $display("FAIL to_rdata: exec_read_data=%h required c0de0009", exec_read_data);
      end
      exec_request = 1'b0;
      @(negedge clock);
      asserts++;
      if ({exec_done, exec_error, bus_vaild} !== 3'b000) begin
         failures++;
         $display("FAIL to_after: done/error/vaild=%b required 000", {exec_done, exec_error, bus_vaild});
      end
      $display("timeout: vaild cycles=%0d", vaild_cycles);
   endtask

   task automatic test_reset_mid_busy();
      exec_request = 1'b1; exec_write = 1'b1;
      exec_address = 32'h0000_5000; exec_write_data = 32'h0BAD_F00D;
      @(negedge clock);
      asserts++;
      if (bus_vaild !== 1'b1) begin
         failures++;
         $display("FAIL rst_busy_pre: bus_vaild=%b required 1", bus_vaild);
      end
      #2 reset = 1'b1;
      #1;
      asserts++;
      if (bus_vaild !== 1'b0 || exec_grant !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy_async: vaild=%b grant=%b required 0 0", bus_vaild, exec_grant);
      end
      @(negedge clock);
      asserts++;
      if ({exec_done, exec_error, bus_vaild} !== 3'b000) begin
         failures++;
         $display("FAIL rst_busy_nodone: done/error/vaild=%b required 000", {exec_done, exec_error, bus_vaild});
      end
      reset = 1'b0;
      @(negedge clock);
      asserts++;
      if ({exec_grant, bus_vaild, exec_done} !== 3'b110 || bus_address !== 32'h0000_5000) begin
         failures++;
         $display("FAIL rst_busy_regrant: grant/vaild/done=%b addr=%h required 110 00005000",
                  {exec_grant, bus_vaild, exec_done}, bus_address);
      end
      bus_ready = 1'b1;
      @(negedge clock);
      bus_ready = 1'b0;
      asserts++;
      if ({exec_done, exec_error} !== 2'b10) begin
         failures++;
         $display("FAIL rst_busy_done: done/error=%b required 10", {exec_done, exec_error});
      end
      exec_request = 1'b0; exec_write = 1'b0;
      @(negedge clock);
      $display("reset_mid_busy: regranted addr=00005000");
   endtask

   task automatic test_stray_ready();
      bus_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         asserts++;
         if ({bus_vaild, fetch_done, exec_done, fetch_grant, exec_grant} !== 5'b0) begin
            failures++;
            $display("FAIL stray[%0d]: vaild/fd/ed/gf/ge=%b required 00000",
                     k, {bus_vaild, fetch_done, exec_done, fetch_grant, exec_grant});
         end
      end
      bus_ready = 1'b0;
      exec_request = 1'b1; exec_write = 1'b0; exec_address = 32'h0000_6000;
      @(negedge clock);
      asserts++;
      if ({exec_grant, bus_vaild} !== 2'b11) begin
         failures++;
         $display("FAIL stray_then_grant: grant/vaild=%b required 11", {exec_grant, bus_vaild});
      end
      bus_ready = 1'b1; bus_data = 32'h7777_0001;
      @(negedge clock);
      bus_ready = 1'b0; exec_request = 1'b0;
      asserts++;
      if (exec_done !== 1'b1 || exec_read_data !== 32'h7777_0001) begin
         failures++;
         $display("FAIL stray_then_done: done=%b rdata=%h required 1 77770001", exec_done, exec_read_data);
      end
      @(negedge clock);
      $display("stray_ready: ignored while idle");
   endtask

   initial begin
      reset = 1'b1;
      fetch_request = 1'b0; fetch_address = '0;
      exec_request = 1'b0; exec_write = 1'b0; exec_address = '0; exec_write_data = '0;
      bus_ready = 1'b0; bus_data = '0;
      test_reset();
      test_exec_write();
      test_fetch_read();
      test_contention();
      test_timeout();
      test_reset_mid_busy();
      test_stray_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule : tb_bus_arbiter
